mem_stage_access: RTL and testbench
===================================

Name: mem_stage_access

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs in the pipelined RISC-V core.
- Turns MemRead/MemWrite requests into a req/ack transaction on a multi-cycle data-memory port.
- Stalls the front of the pipeline until the access completes.
- Contains the MEM/WB register, which it loads once the access completes.

Parameters:
TIMEOUT_CYCLES, 16, max BUSY cycles waiting for mem_ack_i before abort (>=2)
CNT_W, 5, width of wait counter (must hold TIMEOUT_CYCLES)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous, active-low reset
RegWrite_i  in  1  from EX/MEM
MemToReg_i  in  1  from EX/MEM
MemRead_i  in  1  from EX/MEM
MemWrite_i  in  1  from EX/MEM
ALUres_i  in  32  address / ALU result from EX/MEM
RS2data_i  in  32  store data from EX/MEM
RegisterRd_i  in  5  destination register from EX/MEM
mem_req_o  out  1  memory request, registered
mem_we_o  out  1  1=write, 0=read, valid while mem_req_o
mem_addr_o  out  32  word address, valid while mem_req_o
mem_wdata_o  out  32  store data, valid while mem_req_o
mem_ack_i  in  1  memory completes current request this cycle
mem_rdata_i  in  32  read data, valid with mem_ack_i on reads
stall_o  out  1  freeze PC/IFID/IDEX/EXMEM this cycle (combinational)
err_clr_i  in  1  clears err_o
err_o  out  1  sticky access error (misaligned, illegal, timeout)
RegWrite_o  out  1  MEM/WB
MemToReg_o  out  1  MEM/WB
ReadData_o  out  32  MEM/WB load data
ALUres_o  out  32  MEM/WB
RegisterRd_o  out  5  MEM/WB

Behaviour:
- Reset (rst_i=0, any time, incl. mid-transaction):
  - All outputs 0; state IDLE; counter 0.
  - mem_req_o drops without waiting for the clock; any in-flight ack is ignored afterwards.
- access = MemRead_i | MemWrite_i.
- Address checks:
  - misaligned = ALUres_i[1:0] != 0.
  - illegal = MemRead_i & MemWrite_i.
- States: IDLE, BUSY.
- IDLE, access=0:
  - stall_o=0.
  - At the edge MEM/WB loads RegWrite/MemToReg/ALUres/Rd from the inputs; ReadData_o=0.
  - Latency 1 cycle.
- IDLE, access=1, misaligned or illegal:
  - No request; stall_o=0; err_o<=1.
  - MEM/WB loads a bubble: RegWrite_o=0, MemToReg_o=0, RegisterRd_o=0, ALUres_o=ALUres_i, ReadData_o=0.
- IDLE, access=1, legal:
  - stall_o=1 this cycle.
  - At the edge: mem_req_o<=1, mem_we_o<=MemWrite_i, mem_addr_o<=ALUres_i, mem_wdata_o<=RS2data_i; counter<=0; state->BUSY.
  - MEM/WB loads a bubble (RegWrite_o=0, RegisterRd_o=0).
- BUSY, mem_ack_i=0:
  - stall_o=1; mem_* held stable; counter+1.
  - MEM/WB loads a bubble each edge.
- BUSY, mem_ack_i=1:
  - stall_o=0.
  - At the edge: mem_req_o<=0; state->IDLE.
  - MEM/WB loads RegWrite_i, MemToReg_i, ALUres_i, RegisterRd_i (EX/MEM is frozen, so these are still the access's values).
  - ReadData_o<=mem_rdata_i on reads, 0 on writes.
- Minimum load/store latency: 2 cycles, 1 stall cycle.
- Timeout: in BUSY with counter==TIMEOUT_CYCLES-1 and mem_ack_i=0:
  - stall_o=0; mem_req_o<=0; err_o<=1; state->IDLE.
  - MEM/WB loads a bubble; the instruction is squashed.
- Ack and timeout in the same cycle: ack wins, no error.
- mem_ack_i in IDLE: ignored.
- err_o: set by any error event, cleared by err_clr_i. Set and clear in the same cycle: set wins.
- Back-to-back accesses: after an ack the next instruction is seen in IDLE on the following cycle; no request is issued on the ack cycle itself.

Test Plan:
- Reset, then ALU op (RegWrite_i=1, Rd=5, ALUres=0x1234, no mem) -> next edge RegWrite_o=1, RegisterRd_o=5, ALUres_o=0x1234; stall_o never 1; mem_req_o=0.
- Load addr 0x100, Rd=7, memory acks 3 cycles after req rises with rdata 0xDEADBEEF -> mem_req_o high 3 cycles with mem_addr_o=0x100 and mem_we_o=0; stall_o high 3 cycles; RegWrite_o=0 during the stall; then RegWrite_o=1, MemToReg_o=1, ReadData_o=0xDEADBEEF, RegisterRd_o=7.
- Store addr 0x40, data 0xA5A5A5A5, ack in the first BUSY cycle -> mem_we_o=1, mem_wdata_o=0xA5A5A5A5; exactly 1 stall cycle; ReadData_o=0.
- Load addr 0x102 -> no mem_req_o, no stall, err_o=1, RegWrite_o=0. Then err_clr_i pulse -> err_o=0. Repeat with err_clr_i asserted on the error cycle -> err_o=1.
- Load, no ack for TIMEOUT_CYCLES=16 BUSY cycles -> mem_req_o drops after 16 cycles, err_o=1, stall_o released, RegWrite_o=0. Repeat with ack on cycle 16 -> normal completion, err_o=0.
- Assert rst_i=0 mid-BUSY without a clock edge -> mem_req_o and stall_o go 0 immediately. Release reset, then a late mem_ack_i -> ignored, outputs stay 0.

Source files
------------

// File: rtl/mem_stage_access.sv
// MEM-stage data-memory access unit: turns EX/MEM load/store requests into a
// req/ack transaction, stalls the front of the pipeline, and holds the MEM/WB register.
module mem_stage_access #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUres_i,
  input  logic [31:0] RS2data_i,
  input  logic [4:0]  RegisterRd_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  input  logic        err_clr_i,
  output logic        err_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALUres_o,
  output logic [4:0]  RegisterRd_o
);

  // state | meaning
  // IDLE  | no access outstanding; EX/MEM flows straight into MEM/WB
  // BUSY  | request on the memory port, waiting for ack or timeout
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              access, misaligned, illegal, bad;
  logic              stall, err_set;
  logic              req_d, we_d;
  logic [31:0]       addr_d, wdata_d;
  logic              wb_rw_d, wb_mtr_d;
  logic [31:0]       wb_rdata_d, wb_alu_d;
  logic [4:0]        wb_rd_d;

  assign access     = MemRead_i | MemWrite_i;
  assign misaligned = ALUres_i[1:0] != 2'b00;
  assign illegal    = MemRead_i & MemWrite_i;
  assign bad        = access & (misaligned | illegal);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = mem_req_o;
    we_d       = mem_we_o;
    addr_d     = mem_addr_o;
    wdata_d    = mem_wdata_o;
    stall      = 1'b0;
    err_set    = 1'b0;
    wb_rw_d    = 1'b0;
    wb_mtr_d   = 1'b0;
    wb_rdata_d = '0;
    wb_alu_d   = ALUres_i;
    wb_rd_d    = '0;
    case (state_q)
      IDLE: begin
        if (!access) begin
          wb_rw_d  = RegWrite_i;
          wb_mtr_d = MemToReg_i;
          wb_rd_d  = RegisterRd_i;
        end else if (bad) begin
          err_set = 1'b1;
        end else begin
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = MemWrite_i;
          addr_d  = ALUres_i;
          wdata_d = RS2data_i;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // EX/MEM is frozen while stalled, so the inputs still describe this access
        if (mem_ack_i) begin
          req_d      = 1'b0;
          cnt_d      = '0;
          state_d    = IDLE;
          wb_rw_d    = RegWrite_i;
          wb_mtr_d   = MemToReg_i;
          wb_rd_d    = RegisterRd_i;
          wb_rdata_d = mem_we_o ? 32'h0 : mem_rdata_i;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_d   = 1'b0;
          err_set = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Gate with reset so the stall releases the moment reset is asserted
  assign stall_o = rst_i & stall;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_o   <= req_d;
      mem_we_o    <= we_d;
      mem_addr_o  <= addr_d;
      mem_wdata_o <= wdata_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_o        <= 1'b0;
      RegWrite_o   <= 1'b0;
      MemToReg_o   <= 1'b0;
      ReadData_o   <= '0;
      ALUres_o     <= '0;
      RegisterRd_o <= '0;
    end else begin
      err_o        <= err_set | (err_o & ~err_clr_i);
      RegWrite_o   <= wb_rw_d;
      MemToReg_o   <= wb_mtr_d;
      ReadData_o   <= wb_rdata_d;
      ALUres_o     <= wb_alu_d;
      RegisterRd_o <= wb_rd_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench for mem_stage_access: table of single-cycle vectors plus
// hand sequences for loads, stores, timeout and asynchronous reset.
module tb_mem_stage_access;
  localparam int TMO = 16;

  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic        RegWrite_i = 0, MemToReg_i = 0, MemRead_i = 0, MemWrite_i = 0;
  logic [31:0] ALUres_i = '0, RS2data_i = '0, mem_rdata_i = '0;
  logic [4:0]  RegisterRd_i = '0;
  logic        mem_req_o, mem_we_o, mem_ack_i = 0, stall_o, err_clr_i = 0, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, ReadData_o, ALUres_o;
  logic        RegWrite_o, MemToReg_o;
  logic [4:0]  RegisterRd_o;

  int checks = 0;
  int errors = 0;

  mem_stage_access #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUres_i(ALUres_i), .RS2data_i(RS2data_i),
    .RegisterRd_i(RegisterRd_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .err_clr_i(err_clr_i), .err_o(err_o),
    .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o), .ReadData_o(ReadData_o),
    .ALUres_o(ALUres_o), .RegisterRd_o(RegisterRd_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        full;   // 0: only RegWrite/Rd are defined for this bubble
    logic        rw, mtr;
    logic [31:0] rdata, alu;
    logic [4:0]  rd;
  } wb_t;
  wb_t sb[$];

  typedef struct {
    logic        rw, mtr, mr, mw, clr, ack;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        e_rw, e_mtr;
    logic [4:0]  e_rd;
    logic        e_err;
  } vec_t;
  vec_t vecs[11];

  function automatic vec_t mk(input logic rw, mtr, mr, mw, clr, ack, input logic [31:0] alu,
                              input logic [4:0] rd, input logic e_rw, e_mtr,
                              input logic [4:0] e_rd, input logic e_err);
    vec_t v;
    v.rw = rw; v.mtr = mtr; v.mr = mr; v.mw = mw; v.clr = clr; v.ack = ack;
    v.alu = alu; v.rd = rd; v.e_rw = e_rw; v.e_mtr = e_mtr; v.e_rd = e_rd; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_wb(input logic full, rw, mtr, input logic [31:0] rdata, alu,
                         input logic [4:0] rd);
    wb_t e;
    e.full = full; e.rw = rw; e.mtr = mtr; e.rdata = rdata; e.alu = alu; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic pop_wb(input string name);
    wb_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_rw"}, RegWrite_o, e.rw);
      chk({name, "_rd"}, RegisterRd_o, e.rd);
      if (e.full) begin
        chk({name, "_mtr"}, MemToReg_o, e.mtr);
        chk({name, "_rdata"}, ReadData_o, e.rdata);
        chk({name, "_alu"}, ALUres_o, e.alu);
      end
    end
  endtask

  task automatic drive(input logic rw, mtr, mr, mw, input logic [31:0] alu, wdata,
                       input logic [4:0] rd);
    RegWrite_i = rw; MemToReg_i = mtr; MemRead_i = mr; MemWrite_i = mw;
    ALUres_i = alu; RS2data_i = wdata; RegisterRd_i = rd;
  endtask

  // ack_on: BUSY cycle (1-based) on which ack is driven; 0 means never
  task automatic mem_access(input logic we, input logic [31:0] addr, wdata, rdata,
                            input logic [4:0] rd, input int ack_on, input int exp_stalls,
                            input logic exp_err);
    int  stalls, reqs;
    bit  done, exp_stall;
    stalls = 0; reqs = 0; done = 0;
    drive(~we, ~we, ~we, we, addr, wdata, rd);
    mem_ack_i = 0;
    #1;
    chk("idle_stall", stall_o, 1);
    chk("idle_req", mem_req_o, 0);
    stalls += int'(stall_o);
    push_wb(0, 0, 0, 0, addr, 0);
    for (int b = 1; b <= TMO + 1 && !done; b++) begin
      tick();
      pop_wb("busy_wb");
      chk("busy_req", mem_req_o, 1);
      chk("busy_we", mem_we_o, we);
      chk("busy_addr", mem_addr_o, addr);
      if (we) chk("busy_wdata", mem_wdata_o, wdata);
      reqs += int'(mem_req_o);
      mem_ack_i = (b == ack_on);
      mem_rdata_i = rdata;
      #1;
      exp_stall = (b != ack_on) && (b != TMO);
      chk("busy_stall", stall_o, exp_stall);
      stalls += int'(stall_o);
      if (b == ack_on) begin
        push_wb(1, ~we, ~we, we ? 32'h0 : rdata, addr, rd);
        done = 1;
      end else begin
        push_wb(0, 0, 0, 0, addr, 0);
        if (b == TMO) done = 1;
      end
    end
    tick();
    mem_ack_i = 0;
    pop_wb("done_wb");
    chk("done_req", mem_req_o, 0);
    chk("done_err", err_o, exp_err);
    chk("stall_count", stalls, exp_stalls);
    chk("req_count", reqs, (ack_on == 0) ? TMO : ack_on);
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 32'h0000_1234, 5,  1, 0, 5,  0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 31, 1, 0, 31, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 1, 32'h0000_0008, 3,  0, 0, 3,  0);
    vecs[3]  = mk(1, 1, 1, 0, 0, 0, 32'h0000_0102, 7,  0, 0, 0,  1);
    vecs[4]  = mk(0, 0, 0, 0, 1, 0, 32'h0000_0000, 0,  0, 0, 0,  0);
    vecs[5]  = mk(0, 0, 0, 1, 0, 0, 32'h0000_0041, 0,  0, 0, 0,  1);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 32'h0000_0010, 0,  0, 0, 0,  1);
    vecs[7]  = mk(1, 1, 1, 0, 1, 0, 32'h0000_0103, 4,  0, 0, 0,  1);
    vecs[8]  = mk(0, 0, 0, 0, 1, 0, 32'h0000_0000, 0,  0, 0, 0,  0);
    vecs[9]  = mk(1, 1, 1, 1, 0, 0, 32'h0000_0200, 9,  0, 0, 0,  1);
    vecs[10] = mk(1, 1, 0, 0, 1, 0, 32'hCAFE_0000, 12, 1, 1, 12, 0);

    #1;
    chk("rst_req", mem_req_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rw", RegWrite_o, 0);
    chk("rst_rdata", ReadData_o, 0);
    #11 rst_i = 1;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].rw, vecs[i].mtr, vecs[i].mr, vecs[i].mw, vecs[i].alu, 32'h5555_0000, vecs[i].rd);
      err_clr_i = vecs[i].clr;
      mem_ack_i = vecs[i].ack;
      mem_rdata_i = 32'hBAD0_0000 | i;
      #1;
      chk("vec_stall", stall_o, 0);
      push_wb(1, vecs[i].e_rw, vecs[i].e_mtr, 0, vecs[i].alu, vecs[i].e_rd);
      tick();
      pop_wb("vec_wb");
      chk("vec_req", mem_req_o, 0);
      chk("vec_err", err_o, vecs[i].e_err);
    end
    err_clr_i = 0; mem_ack_i = 0;

    mem_access(0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 7, 3, 3, 0);
    mem_access(1, 32'h0000_0040, 32'hA5A5_A5A5, 32'h1111_2222, 0, 1, 1, 0);
    mem_access(0, 32'h0000_0300, 32'h0, 32'h7777_7777, 2, 0, TMO, 1);

    err_clr_i = 1;
    tick();
    err_clr_i = 0;
    chk("clr_after_tmo", err_o, 0);
    mem_access(0, 32'h0000_0304, 32'h0, 32'h0BAD_F00D, 6, TMO, TMO, 0);

    drive(1, 1, 1, 0, 32'h0000_0080, 32'h0, 8);
    tick(); tick(); tick();
    chk("pre_rst_req", mem_req_o, 1);
    #2 rst_i = 0;
    #1;
    chk("arst_req", mem_req_o, 0);
    chk("arst_stall", stall_o, 0);
    chk("arst_addr", mem_addr_o, 0);
    chk("arst_rw", RegWrite_o, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #3 rst_i = 1;
    mem_ack_i = 1;
    mem_rdata_i = 32'h1234_5678;
    tick();
    chk("late_ack_req", mem_req_o, 0);
    chk("late_ack_rdata", ReadData_o, 0);
    chk("late_ack_rw", RegWrite_o, 0);
    chk("late_ack_stall", stall_o, 0);
    mem_ack_i = 0;

    mem_access(1, 32'h0000_0044, 32'h0F0F_0F0F, 32'h0, 0, 2, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
